// File: rtl/pipe_reg_elastic_if.sv
// Valid/ready stream bundle carried between DSP datapath sections.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipe_reg_elastic_if #(
    parameter int WIDTH = 48
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pipe_reg_elastic.sv
// Elastic DEPTH-stage pipeline register for DSP operands and results.
// Each stage carries its own valid flag. Stalled beats pack towards the output, so bubbles
// collapse. A running occupancy count is kept. DEPTH=0 degenerates to a wire-through bypass.
module pipe_reg_elastic #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce_i,
    input  logic               clr_i,
    pipe_reg_elastic_if.slave  in_i,
    pipe_reg_elastic_if.master out_o,
    output logic [CNT_W-1:0]   occupancy_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unusedControls;

            assign out_o.data     = in_i.data;
            assign out_o.valid    = in_i.valid;
            assign in_i.ready     = out_o.ready;
            assign occupancy_o    = '0;
            assign unusedControls = clk ^ rst_n ^ ce_i ^ clr_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] stageValid_q;
            logic [DEPTH-1:0] stageValid_d;
            logic [WIDTH-1:0] stageData_q [DEPTH];
            logic [WIDTH-1:0] stageData_d [DEPTH];
            logic [DEPTH-1:0] stageReady;
            logic [CNT_W-1:0] occupancy_q;
            logic [CNT_W-1:0] occupancy_d;
            logic             advance;
            logic             inFire;
            logic             outFire;

            assign advance     = ce_i & ~clr_i;
            assign in_i.ready  = stageReady[0] & advance & rst_n;
            assign inFire      = in_i.valid & in_i.ready;
            assign outFire     = stageValid_q[DEPTH-1] & out_o.ready & advance;
            assign out_o.valid = stageValid_q[DEPTH-1];
            assign out_o.data  = stageData_q[DEPTH-1];
            assign occupancy_o = occupancy_q;

            // A stage may load unless it and every later stage are full while the output is stalled
            always_comb begin
                stageReady = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    stageReady[k] = out_o.ready
                                  | ~(&(stageValid_q | ((DEPTH'(1) << k) - DEPTH'(1))));
                end
            end

            // Next state: clear flushes everything, otherwise ready stages shift forward when enabled
            always_comb begin
                stageValid_d = stageValid_q;
                stageData_d  = stageData_q;
                occupancy_d  = occupancy_q;
                if (clr_i) begin
                    stageValid_d = '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        stageData_d[k] = '0;
                    end
                    occupancy_d = '0;
                end else if (ce_i) begin
                    if (stageReady[0]) begin
                        stageValid_d[0] = in_i.valid;
                        stageData_d[0]  = in_i.data;
                    end
                    for (int k = 1; k < DEPTH; k++) begin
                        if (stageReady[k]) begin
                            stageValid_d[k] = stageValid_q[k-1];
                            stageData_d[k]  = stageData_q[k-1];
                        end
                    end
                    occupancy_d = occupancy_q + CNT_W'(inFire) - CNT_W'(outFire);
                end
            end

            // Stage and counter registers with asynchronous reset to an empty, zeroed pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stageValid_q <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        stageData_q[k] <= '0;
                    end
                    occupancy_q <= '0;
                end else begin
                    stageValid_q <= stageValid_d;
                    for (int k = 0; k < DEPTH; k++) begin
                        stageData_q[k] <= stageData_d[k];
                    end
                    occupancy_q <= occupancy_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic: four instances (DEPTH 3, 2, 4, 0) share clock, reset,
// ce and clr, and are exercised one scenario at a time with hand-computed expectations.
module tb_pipe_reg_elastic;

    localparam int W = 16;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       clr;
    logic [3:0] occ3;
    logic [3:0] occ2;
    logic [3:0] occ4;
    logic [3:0] occ0;

    int checkCount;
    int errorCount;

    pipe_reg_elastic_if #(.WIDTH(W)) d3In ();
    pipe_reg_elastic_if #(.WIDTH(W)) d3Out ();
    pipe_reg_elastic_if #(.WIDTH(W)) d2In ();
    pipe_reg_elastic_if #(.WIDTH(W)) d2Out ();
    pipe_reg_elastic_if #(.WIDTH(W)) d4In ();
    pipe_reg_elastic_if #(.WIDTH(W)) d4Out ();
    pipe_reg_elastic_if #(.WIDTH(W)) d0In ();
    pipe_reg_elastic_if #(.WIDTH(W)) d0Out ();

    pipe_reg_elastic #(.WIDTH(W), .DEPTH(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .ce_i(ce), .clr_i(clr),
        .in_i(d3In), .out_o(d3Out), .occupancy_o(occ3)
    );
    pipe_reg_elastic #(.WIDTH(W), .DEPTH(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .ce_i(ce), .clr_i(clr),
        .in_i(d2In), .out_o(d2Out), .occupancy_o(occ2)
    );
    pipe_reg_elastic #(.WIDTH(W), .DEPTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ce_i(ce), .clr_i(clr),
        .in_i(d4In), .out_o(d4Out), .occupancy_o(occ4)
    );
    pipe_reg_elastic #(.WIDTH(W), .DEPTH(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce_i(ce), .clr_i(clr),
        .in_i(d0In), .out_o(d0Out), .occupancy_o(occ0)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Drive one bypass vector and give it time to settle
    task automatic applyStimulus(input logic v, input logic r, input logic [W-1:0] d);
        d0In.valid  = v;
        d0In.data   = d;
        d0Out.ready = r;
        #2;
    endtask

    // Scenario sequence
    initial begin
        int acc;
        int left;
        logic expV;
        logic expR;
        logic [W-1:0] expD;

        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        ce    = 1'b1;
        clr   = 1'b0;
        d3In.valid = 1'b0; d3In.data = '0; d3Out.ready = 1'b0;
        d2In.valid = 1'b0; d2In.data = '0; d2Out.ready = 1'b0;
        d4In.valid = 1'b0; d4In.data = '0; d4Out.ready = 1'b0;
        d0In.valid = 1'b0; d0In.data = '0; d0Out.ready = 1'b0;

        // Reset state
        #2;
        checkOutput("rst occ3", 64'(occ3), 64'd0);
        checkOutput("rst valid3", 64'(d3Out.valid), 64'd0);
        checkOutput("rst data3", 64'(d3Out.data), 64'd0);
        checkOutput("rst inready3", 64'(d3In.ready), 64'd0);
        checkOutput("rst inready2", 64'(d2In.ready), 64'd0);
        stepClock();
        stepClock();
        rst_n = 1'b1;
        #1;
        checkOutput("rel inready3", 64'(d3In.ready), 64'd1);

        // T1: asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) begin
            d3In.valid = 1'b1;
            d3In.data  = W'(16'h11 * i);
            stepClock();
        end
        d3In.valid = 1'b1;
        d3In.data  = 16'h44;
        checkOutput("T1 occ full", 64'(occ3), 64'd3);
        checkOutput("T1 head", 64'(d3Out.data), 64'h11);
        checkOutput("T1 inready full", 64'(d3In.ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("T1 async valid", 64'(d3Out.valid), 64'd0);
        checkOutput("T1 async data", 64'(d3Out.data), 64'd0);
        checkOutput("T1 async occ", 64'(occ3), 64'd0);
        checkOutput("T1 async inready", 64'(d3In.ready), 64'd0);
        stepClock();
        checkOutput("T1 held inready", 64'(d3In.ready), 64'd0);
        checkOutput("T1 held valid", 64'(d3Out.valid), 64'd0);
        d3In.valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("T1 rel inready", 64'(d3In.ready), 64'd1);

        // T2: latency and throughput, beats 1..8 on DEPTH=3
        d3Out.ready = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            d3In.valid = (e <= 8);
            d3In.data  = W'(e);
            stepClock();
            acc  = (e < 8) ? e : 8;
            left = e - 3;
            if (left < 0) left = 0;
            if (left > 8) left = 8;
            checkOutput($sformatf("T2 valid e%0d", e), 64'(d3Out.valid), 64'((e >= 3) && (e <= 10)));
            if ((e >= 3) && (e <= 10)) begin
                checkOutput($sformatf("T2 data e%0d", e), 64'(d3Out.data), 64'(e - 2));
            end
            checkOutput($sformatf("T2 occ e%0d", e), 64'(occ3), 64'(acc - left));
        end
        d3In.valid = 1'b0;

        // T3: backpressure on DEPTH=2
        d2Out.ready = 1'b0;
        d2In.valid  = 1'b1;
        d2In.data   = 16'hA;
        #1;
        checkOutput("T3 ready A", 64'(d2In.ready), 64'd1);
        stepClock();
        checkOutput("T3 occ 1", 64'(occ2), 64'd1);
        d2In.data = 16'hB;
        #1;
        checkOutput("T3 ready B", 64'(d2In.ready), 64'd1);
        stepClock();
        checkOutput("T3 occ 2", 64'(occ2), 64'd2);
        checkOutput("T3 head A", 64'(d2Out.data), 64'hA);
        d2In.data = 16'hC;
        #1;
        checkOutput("T3 ready full", 64'(d2In.ready), 64'd0);
        stepClock();
        checkOutput("T3 hold occ", 64'(occ2), 64'd2);
        checkOutput("T3 hold head", 64'(d2Out.data), 64'hA);
        d2Out.ready = 1'b1;
        #1;
        checkOutput("T3 ready release", 64'(d2In.ready), 64'd1);
        stepClock();
        d2In.valid = 1'b0;
        checkOutput("T3 out B", 64'(d2Out.data), 64'hB);
        checkOutput("T3 occ swap", 64'(occ2), 64'd2);
        stepClock();
        checkOutput("T3 out C", 64'(d2Out.data), 64'hC);
        checkOutput("T3 valid C", 64'(d2Out.valid), 64'd1);
        checkOutput("T3 occ drain", 64'(occ2), 64'd1);
        stepClock();
        checkOutput("T3 empty", 64'(d2Out.valid), 64'd0);
        checkOutput("T3 occ empty", 64'(occ2), 64'd0);

        // T4: bubble collapse on DEPTH=4
        d4Out.ready = 1'b0;
        d4In.valid  = 1'b1;
        d4In.data   = 16'h5;
        stepClock();
        d4In.valid = 1'b0;
        checkOutput("T4 occ 1", 64'(occ4), 64'd1);
        stepClock();
        stepClock();
        d4In.valid = 1'b1;
        d4In.data  = 16'h6;
        #1;
        checkOutput("T4 ready 6", 64'(d4In.ready), 64'd1);
        stepClock();
        d4In.valid = 1'b0;
        checkOutput("T4 occ 2", 64'(occ4), 64'd2);
        checkOutput("T4 head 5", 64'(d4Out.data), 64'h5);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("T4 packed occ", 64'(occ4), 64'd2);
        checkOutput("T4 packed head", 64'(d4Out.data), 64'h5);
        checkOutput("T4 packed ready", 64'(d4In.ready), 64'd1);
        d4Out.ready = 1'b1;
        stepClock();
        checkOutput("T4 next 6", 64'(d4Out.data), 64'h6);
        checkOutput("T4 valid 6", 64'(d4Out.valid), 64'd1);
        stepClock();
        checkOutput("T4 empty", 64'(d4Out.valid), 64'd0);
        checkOutput("T4 occ empty", 64'(occ4), 64'd0);

        // T5: clock enable freeze then clear on DEPTH=3
        d3Out.ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            d3In.valid = 1'b1;
            d3In.data  = W'(16'h70 + i);
            stepClock();
        end
        checkOutput("T5 occ full", 64'(occ3), 64'd3);
        ce          = 1'b0;
        d3Out.ready = 1'b1;
        d3In.data   = 16'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("T5 ce0 ready c%0d", i), 64'(d3In.ready), 64'd0);
            stepClock();
            checkOutput($sformatf("T5 ce0 occ c%0d", i), 64'(occ3), 64'd3);
            checkOutput($sformatf("T5 ce0 head c%0d", i), 64'(d3Out.data), 64'h71);
        end
        clr = 1'b1;
        #1;
        checkOutput("T5 clr ready", 64'(d3In.ready), 64'd0);
        stepClock();
        clr = 1'b0;
        ce  = 1'b1;
        checkOutput("T5 clr occ", 64'(occ3), 64'd0);
        checkOutput("T5 clr valid", 64'(d3Out.valid), 64'd0);
        checkOutput("T5 clr data", 64'(d3Out.data), 64'd0);
        d3In.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepClock();
            checkOutput($sformatf("T5 dropped c%0d", i), 64'(d3Out.valid), 64'd0);
        end

        // T6: DEPTH=0 bypass, with ce/clr toggled to show they are ignored
        for (int i = 0; i < 10; i++) begin
            expV = 1'($urandom_range(0, 1));
            expR = 1'($urandom_range(0, 1));
            expD = W'($urandom);
            ce   = 1'($urandom_range(0, 1));
            clr  = 1'($urandom_range(0, 1));
            applyStimulus(expV, expR, expD);
            checkOutput($sformatf("T6 data v%0d", i), 64'(d0Out.data), 64'(expD));
            checkOutput($sformatf("T6 valid v%0d", i), 64'(d0Out.valid), 64'(expV));
            checkOutput($sformatf("T6 ready v%0d", i), 64'(d0In.ready), 64'(expR));
            checkOutput($sformatf("T6 occ v%0d", i), 64'(occ0), 64'd0);
        end
        ce  = 1'b1;
        clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
